// File: rtl/sigma_np.sv
// Sums N = 2**LOG2N sign-magnitude samples qualified by a slow strobe, either as
// non-overlapping blocks (mode=0) or as a moving window (mode=1).
module sigma_np #(
  parameter  int DW    = 8,
  parameter  int LOG2N = 4,
  localparam int OW    = DW + LOG2N
) (
  input  logic          clk,
  input  logic          res,
  input  logic [DW-1:0] data_in,
  input  logic          syn_in,
  input  logic          mode,
  output logic [OW-1:0] data_out,
  output logic          syn_out
);

  localparam int N  = 1 << LOG2N;
  localparam int CW = LOG2N + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WARM = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  function automatic logic signed [DW:0] sm_to_tc(input logic [DW-1:0] s);
    logic [DW:0] mag;
    mag = {2'b00, s[DW-2:0]};
    return s[DW-1] ? signed'(-mag) : signed'(mag);
  endfunction

  state_t                state_q, state_d;
  logic                  syn_q;
  logic                  mode_q;
  logic                  pulse_q;
  logic signed [DW:0]    d_q;
  logic signed [OW-1:0]  acc_q, acc_d;
  logic [LOG2N-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic [OW-1:0]         data_out_q, data_out_d;
  logic                  syn_out_q, syn_out_d;
  logic signed [DW:0]    hist_q [N];

  logic                  syn_pulse;
  logic                  mode_chg;
  logic                  shift_en;
  logic                  clr_hist;
  logic signed [OW-1:0]  d_ext;
  logic signed [OW-1:0]  tail_ext;

  assign syn_pulse = syn_in & ~syn_q;
  assign mode_chg  = mode ^ mode_q;
  assign data_out  = data_out_q;
  assign syn_out   = syn_out_q;

  // The sample is captured at the strobe edge and accumulated one clock later.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    data_out_d = data_out_q;
    syn_out_d  = 1'b0;
    shift_en   = 1'b0;
    clr_hist   = 1'b0;
    d_ext      = OW'(d_q);
    tail_ext   = OW'(hist_q[N-1]);
    if (mode_chg) begin
      acc_d    = '0;
      cnt_d    = '0;
      fill_d   = '0;
      clr_hist = 1'b1;
      state_d  = mode ? S_WARM : S_ACC;
    end else begin
      case (state_q)
        S_IDLE: state_d = mode_q ? S_WARM : S_ACC;
        S_ACC: begin
          if (pulse_q) begin
            if (cnt_q == LOG2N'(N - 1)) begin
              data_out_d = acc_q + d_ext;
              syn_out_d  = 1'b1;
              acc_d      = '0;
              cnt_d      = '0;
            end else begin
              acc_d = acc_q + d_ext;
              cnt_d = cnt_q + LOG2N'(1);
            end
          end
        end
        S_WARM, S_RUN: begin
          if (pulse_q) begin
            acc_d    = acc_q + d_ext - tail_ext;
            shift_en = 1'b1;
            if (state_q == S_RUN) begin
              data_out_d = acc_d;
              syn_out_d  = 1'b1;
            end else if (fill_q == CW'(N - 1)) begin
              fill_d     = CW'(N);
              data_out_d = acc_d;
              syn_out_d  = 1'b1;
              state_d    = S_RUN;
            end else begin
              fill_d = fill_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      syn_q      <= 1'b0;
      mode_q     <= 1'b0;
      pulse_q    <= 1'b0;
      d_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      fill_q     <= '0;
      data_out_q <= '0;
      syn_out_q  <= 1'b0;
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      syn_q      <= syn_in;
      mode_q     <= mode;
      // A strobe coinciding with a mode change is dropped.
      pulse_q    <= syn_pulse & ~mode_chg;
      d_q        <= sm_to_tc(data_in);
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      data_out_q <= data_out_d;
      syn_out_q  <= syn_out_d;
      if (clr_hist) begin
        for (int i = 0; i < N; i++) hist_q[i] <= '0;
      end else if (shift_en) begin
        hist_q[0] <= d_q;
        for (int i = 1; i < N; i++) hist_q[i] <= hist_q[i-1];
      end
    end
  end

endmodule

// File: doc/sigma_np.md
# sigma_np

Parametrised successor of the 16-point adjacent-sample accumulator. It sums N = 2^LOG2N consecutive samples from a sign-magnitude sample stream qualified by a slow sample strobe. Two run-time modes are supported: block (one result per N samples) and sliding (a moving sum, one result per sample once the window is full). It sits in the same front-end position as the 16-point summer, between the sampler and the downstream filter/decimation logic.

## Interface
- DW, default 8: input sample width, sign-magnitude; bit DW-1 is the sign.
- LOG2N, default 4: log2 of the window length N (N = 16 by default). Legal range is 1..8.
- OW, derived as DW+LOG2N (12 by default): output width, two's complement. Not user-overridable.
- clk  input  1  system clock; all logic is on the rising edge.
- res  input  1  reset, synchronous, active-high.
- data_in  input  DW  sample value, sign-magnitude, valid when syn_in rises.
- syn_in  input  1  sample strobe, a level signal; its rising edge marks one sample.
- mode  input  1  0 = block sum, 1 = sliding sum.
- data_out  output  OW  accumulated sum, two's complement, held between updates.
- syn_out  output  1  one-cycle pulse, high in the cycle data_out takes a new value.

## Operation
- **Edge detect.**
  - syn_d is syn_in registered.
  - syn_pulse = syn_in & ~syn_d.
  - A strobe held high for many cycles counts as exactly one sample.
- **Conversion.**
  - A positive sample gives d = zero-extended magnitude.
  - A negative sample gives d = -(data_in[DW-2:0]).
  - Negative zero (sign bit set, magnitude 0) gives d = 0.
  - d is sign-extended to OW bits.
- **Arithmetic.**
  - |sum| ≤ N·(2^(DW-1)-1) fits in OW signed bits.
  - No saturation or overflow handling is required. Any overflow is a design bug.
- **Block mode (mode=0).**
  - Sample counter cnt runs 0..N-1. Accumulator is acc.
  - On a syn_pulse with cnt < N-1: acc += d, cnt += 1.
  - On a syn_pulse with cnt == N-1:
    - data_out <= acc + d (the result includes the current sample);
    - syn_out <= 1;
    - acc <= 0, cnt <= 0.
- **Sliding mode (mode=1).**
  - History is an N-entry shift register of converted samples (DW+1 bits each), initially all zero.
  - On each syn_pulse:
    - acc <= acc + d - hist[N-1];
    - shift d into hist[0];
    - fill counter increments, saturating at N.
  - When the fill count reaches N on a pulse (the Nth sample and every later one):
    - data_out <= new acc;
    - syn_out <= 1.
  - Before the window is full there is no output pulse.
- **Mode change.**
  - mode is registered as mode_q.
  - In any cycle where mode != mode_q:
    - acc, cnt, fill and hist are cleared;
    - a coincident syn_pulse is discarded.
  - data_out holds its last value.
- **FSM.** States are IDLE/ACC and WARM/RUN.
  - Block mode: ACC runs continuously.
  - Sliding mode: WARM while fill < N, RUN once the window is full.

## Timing
- **Reset.** res high at a clock edge sets the following to 0 at that edge:
  - data_out, syn_out, acc, cnt, fill, hist, syn_d, mode_q.
  - Reset has priority over everything, including a mid-window reset; the partial sum is discarded.
- **Latency.** syn_in is first sampled high at edge k. Then:
  - data_out and syn_out update at edge k+1, i.e. the pulse is recognised at edge k and the registered result appears after it.
  - syn_out is high for exactly one clock.
- **Throughput.**
  - Samples may arrive every 2 clocks at the fastest (strobe low ≥1 cycle, high ≥1 cycle).
  - No back-pressure is supported.
- **Wrap.**
  - Block mode: cnt wraps N-1 → 0 with no gap; the next sample starts a new block.
  - Sliding mode: output continues on every pulse with no re-warm-up.

## Test plan
- **Block, positive.**
  - Stimulus: mode=0, 16 pulses of data_in=8'h05.
  - Response: one syn_out pulse after the 16th sample with data_out=12'h050, and no pulse on samples 1–15.
- **Block, signs and limits.** Each case is 16 samples.
  - 8'h85 gives 12'hFB0 (-80).
  - 8'h7F gives 12'h7F0 (2032).
  - 8'hFF gives 12'h810 (-2032).
  - 8'h80 gives 12'h000.
- **Sliding.**
  - Stimulus: mode=1, samples 1,2,…,20.
  - Response: first syn_out after sample 16 with data_out=136, then 152, 168, 184, 200. No pulse before sample 16.
- **Strobe holding.**
  - Stimulus: syn_in held high 10 cycles per sample, block mode, 16×8'h01.
  - Response: a single result of 12'h010 with a single syn_out.
- **Mode toggle.**
  - Stimulus: after 7 block samples, set mode=1 in the same cycle as a pulse.
  - Response: that sample is discarded. 16 further samples of 8'h02 give first data_out=32.
- **Reset mid-window.**
  - Stimulus: assert res for 1 cycle after 9 samples of 8'h10.
  - Response: data_out=0 and syn_out=0 the next cycle. The next 16 samples of 8'h01 give 12'h010.
